lcd_msg_sequencer: RTL and testbench
====================================

Name: lcd_msg_sequencer

Overview:
- Accepts 4-character messages over a valid/ready handshake and scrolls them into the 4-character display register one character per step.
- Drives char1..char4 and a one-cycle show strobe straight into the display register block.
- Each character is held for a programmable number of cycles before the next step.
- Sits between message sources (UART decoder, status logic) and the display register.

Parameters:
- HOLD_CYCLES, 2, idle cycles after each show strobe before the next step (0 allowed: steps back-to-back).
- MSG_CHARS, 4, characters per message; fixed at 4 in this revision.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- msg_valid  in  1  source has a message.
- msg_data  in  32  message; [31:24] is the first character, [7:0] the last.
- msg_ready  out  1  sequencer can accept a message.
- char1  out  8  window slot 1 (oldest).
- char2  out  8  window slot 2.
- char3  out  8  window slot 3.
- char4  out  8  window slot 4 (newest; the character shown).
- show  out  1  one-cycle load strobe to the display register.
- busy  out  1  high from acceptance until the cycle before return to IDLE.
- done  out  1  one-cycle pulse when a pass completes.

Behaviour:
- Reset is synchronous and active-high, on clk:
  - state=IDLE; char1..char4=8'h20; show=0; busy=0; done=0; msg_ready=1; step index=0; hold counter=0.
  - rst high mid-sequence aborts at that edge; the message is discarded and no done is issued.
- States: IDLE, SHOW, HOLD, DONE. All outputs are registered.
- IDLE:
  - msg_ready=1.
  - On msg_valid&&msg_ready at edge T: latch msg_data into the buffer, idx=0, go to SHOW.
- SHOW, one cycle, entered at T+1 for the first step:
  - In that cycle: char1<=char2, char2<=char3, char3<=char4, char4<=buf[idx], so the window is already updated; show=1.
  - Next state: HOLD if HOLD_CYCLES>0.
  - Otherwise: SHOW (idx+1) if idx<3, else DONE.
- HOLD:
  - Counts HOLD_CYCLES cycles with show=0.
  - At expiry: idx<3 → idx+1, SHOW; idx==3 → DONE.
- DONE, one cycle: done=1, busy=1, then IDLE (msg_ready=1 in the following cycle).
- Step period = HOLD_CYCLES+1 cycles. Accept-to-done latency = 4*(HOLD_CYCLES+1)+1 cycles.
- msg_ready=0 in SHOW, HOLD and DONE. msg_valid during those states is ignored; the source must hold it.
- The window keeps its last contents after DONE. A new message scrolls in over the old characters.
- Hold counter width = $clog2(HOLD_CYCLES+1), minimum 1 bit. The counter saturates and never wraps.
- msg_valid and rst high in the same cycle: reset wins and nothing is accepted.

Optional Feature:
- Macro LCD_SEQ_LOOP_EN.
- Defined:
  - Adds input port loop_en (1 bit).
  - In DONE with loop_en=1: next state is SHOW with idx=0 and the same buffer, which rescrolls the message. done still pulses each pass.
  - loop_en sampled low in DONE: go to IDLE.
  - Deasserting loop_en mid-pass lets that pass complete.
- Undefined: no loop_en port; DONE always returns to IDLE.

Decomposition:
- Package lcd_pkg:
  - state enum lcd_seq_state_t {IDLE, SHOW, HOLD, DONE}.
  - constant LCD_SPACE=8'h20.
  - constant LCD_MSG_CHARS=4.
- One natural sub-module: lcd_hold_timer (load/expire down-counter, parameter HOLD_CYCLES). Instantiated once.
- The shift window and FSM stay in the top module.

Test Plan:
- Single message, HOLD_CYCLES=2: accept 32'h41424344 at T.
  - show high at T+1, T+4, T+7, T+10.
  - char4 = 41, 42, 43, 44 at those cycles.
  - At T+1: char1..char4 = 20 20 20 41.
  - Final window 41 42 43 44; done at T+13; msg_ready high at T+14.
- Back-pressure: hold msg_valid with 32'h31323334 while busy → msg_ready=0 until T+14; accepted at T+14; first show at T+15 with char4=31.
- HOLD_CYCLES=0, message 32'h61626364 → show high for four consecutive cycles, char4 = 61..64; done at T+5.
- Reset mid-operation: assert rst for one cycle at T+5 of the first test → next cycle: char1..char4=20, show=0, busy=0, done never pulses, msg_ready=1.
- LCD_SEQ_LOOP_EN defined, loop_en=1, message 32'h41424344, HOLD_CYCLES=2:
  - done at T+13.
  - show at T+14 with char4=41 and window 42 43 44 41.
  - Drop loop_en during the second pass → second done, then IDLE.
- Simultaneous rst and msg_valid in IDLE → message not accepted; no show in the following 5 cycles.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD message sequencer.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } lcd_seq_state_t;

    localparam logic [7:0] LCD_SPACE     = 8'h20;
    localparam int         LCD_MSG_CHARS = 4;

    // Character idx of a message; idx 0 is the first character, in bits [31:24].
    function automatic logic [7:0] lcd_msg_char(input logic [31:0] msg, input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = msg[31:24];
            2'd1:    c = msg[23:16];
            2'd2:    c = msg[15:8];
            default: c = msg[7:0];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_hold_timer.sv
// Hold timer: loads HOLD_CYCLES, counts down while enabled, saturates at zero.
// expire is high during the last cycle of the hold interval.
module lcd_hold_timer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int            CW       = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES);

    logic [CW-1:0] cnt;

    // Down-counter; never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt <= CW'(1));

endmodule

// File: rtl/lcd_msg_sequencer.sv
// Scrolls 4-character messages into the display window one character per step.
// Optional feature macro LCD_SEQ_LOOP_EN adds loop_en: rescroll the same message while high.
//
//  state | meaning
//  IDLE  | waiting for a message, msg_ready high
//  SHOW  | window just shifted, show strobe high for one cycle
//  HOLD  | holding the shown character for HOLD_CYCLES cycles
//  DONE  | one-cycle done pulse, then IDLE (or SHOW again when looping)
module lcd_msg_sequencer
    import lcd_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int MSG_CHARS   = LCD_MSG_CHARS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_valid,
    input  logic [31:0] msg_data,
`ifdef LCD_SEQ_LOOP_EN
    input  logic        loop_en,
`endif
    output logic        msg_ready,
    output logic [7:0]  char1,
    output logic [7:0]  char2,
    output logic [7:0]  char3,
    output logic [7:0]  char4,
    output logic        show,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDX_LAST = 2'(MSG_CHARS - 1);

    lcd_seq_state_t state, state_n;
    logic [1:0]     idx, idx_n;
    logic [31:0]    msg_buf, buf_n;
    logic           expire;
    logic           show_n, busy_n, done_n, ready_n;

    lcd_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .load   (state == SHOW),
        .en     (state == HOLD),
        .expire (expire)
    );

    // Next-state decode; outputs are derived from the next state so they register with it.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        buf_n   = msg_buf;
        case (state)
            IDLE: begin
                if (msg_valid && msg_ready) begin
                    buf_n   = msg_data;
                    idx_n   = '0;
                    state_n = SHOW;
                end
            end
            SHOW: begin
                if (HOLD_CYCLES > 0) begin
                    state_n = HOLD;
                end else if (idx != IDX_LAST) begin
                    idx_n   = idx + 1'b1;
                    state_n = SHOW;
                end else begin
                    state_n = DONE;
                end
            end
            HOLD: begin
                if (expire) begin
                    if (idx != IDX_LAST) begin
                        idx_n   = idx + 1'b1;
                        state_n = SHOW;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
`ifdef LCD_SEQ_LOOP_EN
                if (loop_en) begin
                    idx_n   = '0;
                    state_n = SHOW;
                end else begin
                    state_n = IDLE;
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
        show_n  = (state_n == SHOW);
        done_n  = (state_n == DONE);
        busy_n  = (state_n != IDLE);
        ready_n = (state_n == IDLE);
    end

    // State, window and output registers; the window shifts on entry to SHOW.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            msg_buf   <= '0;
            char1     <= LCD_SPACE;
            char2     <= LCD_SPACE;
            char3     <= LCD_SPACE;
            char4     <= LCD_SPACE;
            show      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            msg_ready <= 1'b1;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            msg_buf   <= buf_n;
            show      <= show_n;
            busy      <= busy_n;
            done      <= done_n;
            msg_ready <= ready_n;
            if (show_n) begin
                char1 <= char2;
                char2 <= char3;
                char3 <= char4;
                char4 <= lcd_msg_char(buf_n, idx_n);
            end
        end
    end

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Bench for lcd_msg_sequencer: two instances (HOLD_CYCLES=2 and 0) share randomized
// stimulus and are compared every cycle against an offset-based behavioural model.
module tb_lcd_msg_sequencer;

`ifdef LCD_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        msg_valid;
    logic [31:0] msg_data;
    logic        loop_en;

    logic       rdy0, show0, busy0, done0, rdy1, show1, busy1, done1;
    logic [7:0] c1_0, c2_0, c3_0, c4_0, c1_1, c2_1, c3_1, c4_1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    lcd_msg_sequencer #(.HOLD_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_data(msg_data),
`ifdef LCD_SEQ_LOOP_EN
        .loop_en(loop_en),
`endif
        .msg_ready(rdy0), .char1(c1_0), .char2(c2_0), .char3(c3_0), .char4(c4_0),
        .show(show0), .busy(busy0), .done(done0)
    );

    lcd_msg_sequencer #(.HOLD_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_data(msg_data),
`ifdef LCD_SEQ_LOOP_EN
        .loop_en(loop_en),
`endif
        .msg_ready(rdy1), .char1(c1_1), .char2(c2_1), .char3(c3_1), .char4(c4_1),
        .show(show1), .busy(busy1), .done(done1)
    );

    wire [36:0] obs0 = {rdy0, show0, busy0, done0, c1_0, c2_0, c3_0, c4_0};
    wire [36:0] obs1 = {rdy1, show1, busy1, done1, c1_1, c2_1, c3_1, c4_1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // A pass is described by the cycle offset since acceptance: step j shows at
    // offset 1 + j*(H+1), done at offset 4*(H+1)+1.
    bit          m_act [2];
    int          m_off [2];
    logic [31:0] m_msg [2];
    logic [7:0]  m_win [2][4];
    bit          e_show [2];
    bit          e_done [2];

    function automatic int hold_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic model_step(input int d);
        int p, l, j;
        p = hold_of(d) + 1;
        l = 4 * p + 1;
        e_show[d] = 1'b0;
        e_done[d] = 1'b0;
        if (rst) begin
            m_act[d] = 1'b0;
            for (int i = 0; i < 4; i++) m_win[d][i] = 8'h20;
        end else if (!m_act[d]) begin
            if (msg_valid) begin
                m_act[d] = 1'b1;
                m_msg[d] = msg_data;
                m_off[d] = 1;
            end
        end else if (m_off[d] == l) begin
            if (LOOP && loop_en) m_off[d] = 1;
            else                 m_act[d] = 1'b0;
        end else begin
            m_off[d] = m_off[d] + 1;
        end
        if (m_act[d]) begin
            if (m_off[d] < l && ((m_off[d] - 1) % p) == 0) begin
                j = (m_off[d] - 1) / p;
                e_show[d] = 1'b1;
                for (int i = 0; i < 3; i++) m_win[d][i] = m_win[d][i + 1];
                m_win[d][3] = m_msg[d][31 - 8 * j -: 8];
            end
            e_done[d] = (m_off[d] == l);
        end
    endtask

    function automatic logic [36:0] expv(input int d);
        return {!m_act[d], e_show[d], m_act[d], e_done[d],
                m_win[d][0], m_win[d][1], m_win[d][2], m_win[d][3]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    initial begin
        forever begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
            chk("model_h2", {27'd0, obs0}, {27'd0, expv(0)});
            chk("model_h0", {27'd0, obs1}, {27'd0, expv(1)});
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(rdy0 && rdy1) && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", {63'd0, rdy0 && rdy1}, 64'd1);
    endtask

    function automatic logic [7:0] b_char4(input int k);
        case (k)
            1:       return 8'h41;
            4:       return 8'h42;
            7:       return 8'h43;
            10:      return 8'h44;
            default: return 8'h31;
        endcase
    endfunction

    initial begin
        bit saw_done;
        rst       = 1'b1;
        msg_valid = 1'b0;
        msg_data  = '0;
        loop_en   = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_window", {32'd0, c1_0, c2_0, c3_0, c4_0}, 64'h20202020);
        chk("reset_flags", {60'd0, rdy0, show0, busy0, done0}, 64'b1000);

        // Single message with back-pressured follow-up.
        msg_valid = 1'b1;
        msg_data  = 32'h41424344;
        tick();
        msg_valid = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            chk("b_show", {63'd0, show0}, {63'd0, (k == 1 || k == 4 || k == 7 || k == 10 || k == 15)});
            chk("b_done", {63'd0, done0}, {63'd0, k == 13});
            chk("b_ready", {63'd0, rdy0}, {63'd0, k == 14});
            if (k == 1 || k == 4 || k == 7 || k == 10 || k == 15)
                chk("b_char4", {56'd0, c4_0}, {56'd0, b_char4(k)});
            if (k == 1)  chk("b_win_first", {32'd0, c1_0, c2_0, c3_0, c4_0}, 64'h20202041);
            if (k == 13) chk("b_win_final", {32'd0, c1_0, c2_0, c3_0, c4_0}, 64'h41424344);
            if (k == 15) chk("b_win_next", {32'd0, c1_0, c2_0, c3_0, c4_0}, 64'h42434431);
            if (k == 2) begin
                msg_valid = 1'b1;
                msg_data  = 32'h31323334;
            end
            tick();
        end
        msg_valid = 1'b0;

        // Reset in the middle of a pass.
        wait_idle();
        msg_valid = 1'b1;
        msg_data  = 32'h41424344;
        tick();
        msg_valid = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("c_win", {32'd0, c1_0, c2_0, c3_0, c4_0}, 64'h20202020);
        chk("c_flags", {60'd0, rdy0, show0, busy0, done0}, 64'b1000);
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            saw_done = saw_done | done0;
            tick();
        end
        chk("c_no_done", {63'd0, saw_done}, 64'd0);

        // Back-to-back steps with HOLD_CYCLES=0.
        wait_idle();
        msg_valid = 1'b1;
        msg_data  = 32'h61626364;
        tick();
        msg_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk("d_show", {63'd0, show1}, {63'd0, k <= 4});
            if (k <= 4) chk("d_char4", {56'd0, c4_1}, {56'd0, 8'(8'h60 + k)});
            chk("d_done", {63'd0, done1}, {63'd0, k == 5});
            chk("d_ready", {63'd0, rdy1}, {63'd0, k == 6});
            tick();
        end

        // Reset and valid together: nothing accepted.
        wait_idle();
        rst       = 1'b1;
        msg_valid = 1'b1;
        msg_data  = 32'h55565758;
        tick();
        rst       = 1'b0;
        msg_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("e_no_show", {62'd0, show0, show1}, 64'd0);
            tick();
        end

`ifdef LCD_SEQ_LOOP_EN
        // Looping rescroll, loop_en dropped during the second pass.
        wait_idle();
        loop_en   = 1'b1;
        msg_valid = 1'b1;
        msg_data  = 32'h41424344;
        tick();
        msg_valid = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            chk("f_done", {63'd0, done0}, {63'd0, (k == 13 || k == 26)});
            if (k == 14) begin
                chk("f_show", {63'd0, show0}, 64'd1);
                chk("f_win", {32'd0, c1_0, c2_0, c3_0, c4_0}, 64'h42434441);
            end
            if (k == 27) chk("f_idle", {62'd0, rdy0, busy0}, 64'b10);
            if (k == 16) loop_en = 1'b0;
            tick();
        end
`endif

        // Randomized traffic, checked by the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 149) == 0);
            msg_valid = ($urandom_range(0, 2) != 0);
            msg_data  = $urandom;
            loop_en   = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst       = 1'b0;
        msg_valid = 1'b0;
        loop_en   = 1'b0;
        wait_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
